// File: rtl/evt_sync_pkg.sv
// Shared FSM encoding, metadata-flag position and event-ID helper for the event aligner.
package evt_sync_pkg;

    typedef logic [0:0] state_t;

    localparam state_t WAIT_HDR = 1'b0;
    localparam state_t FWD      = 1'b1;

    localparam int unsigned EVTID_MAX_WIDTH = 64;

    // The metadata flag sits directly above the payload bits.
    function automatic int unsigned meta_bit(input int unsigned data_width);
        return data_width;
    endfunction

    function automatic logic evtid_differs(input logic [EVTID_MAX_WIDTH-1:0] a,
                                           input logic [EVTID_MAX_WIDTH-1:0] b,
                                           input int unsigned width);
        logic [EVTID_MAX_WIDTH-1:0] mask;
        for (int unsigned k = 0; k < EVTID_MAX_WIDTH; k++) begin
            mask[k] = (k < width);
        end
        return ((a ^ b) & mask) != '0;
    endfunction

endpackage

// File: rtl/evt_sync_fifo.sv
// First-word-fall-through FIFO of 2**ADDR_WIDTH words; a word written at one edge is at the
// head from the next cycle.
module evt_sync_fifo #(
    parameter int unsigned WIDTH      = 65,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             head_valid,
    output logic             full
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;

    // The extra pointer bit separates full from empty once the pointers wrap.
    assign head_valid = (wr_ptr != rd_ptr);
    assign full       = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                        (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign head       = mem[rd_ptr[ADDR_WIDTH-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop && head_valid) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/evt_sync_aligner.sv
// Aligns header/footer-framed events across channels and forwards them per channel.
// Optional header-wait timeout is enabled by defining EVT_SYNC_TIMEOUT_EN.
module evt_sync_aligner
    import evt_sync_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned FIFO_DEPTH     = 6,
    parameter int unsigned N_CHANNELS     = 2,
    parameter int unsigned EVTID_WIDTH    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [N_CHANNELS-1:0][DATA_WIDTH:0]  in_data,
    input  logic [N_CHANNELS-1:0]                in_valid,
    output logic [N_CHANNELS-1:0]                in_ready,
    output logic [N_CHANNELS-1:0][DATA_WIDTH:0]  out_data,
    output logic [N_CHANNELS-1:0]                out_valid,
    input  logic [N_CHANNELS-1:0]                out_ready,
    output logic                                 err_evtid,
    output logic                                 err_orphan,
`ifdef EVT_SYNC_TIMEOUT_EN
    output logic                                 err_timeout,
`endif
    output logic [31:0]                          event_count
);

    localparam int unsigned META = meta_bit(DATA_WIDTH);

    if (N_CHANNELS < 1 || N_CHANNELS > 16 || TIMEOUT_CYCLES < 1 ||
        EVTID_WIDTH > DATA_WIDTH || EVTID_WIDTH > EVTID_MAX_WIDTH) begin : g_bad_params
        $error("evt_sync_aligner: illegal parameter combination");
    end

    logic [N_CHANNELS-1:0][DATA_WIDTH:0] head;
    logic [N_CHANNELS-1:0] head_valid, head_meta, full, push, pop;
    logic [N_CHANNELS-1:0] done_q, done_d, hdr_q, hdr_d;
    state_t                state_q, state_d;
    logic                  err_evtid_d, err_orphan_d, all_hdr, timeout_fire;
    logic [31:0]           count_d;

    for (genvar i = 0; i < N_CHANNELS; i++) begin : g_chan
        evt_sync_fifo #(
            .WIDTH      (DATA_WIDTH + 1),
            .ADDR_WIDTH (FIFO_DEPTH)
        ) u_fifo (
            .clock      (clock),
            .reset      (reset),
            .push       (push[i]),
            .push_data  (in_data[i]),
            .pop        (pop[i]),
            .head       (head[i]),
            .head_valid (head_valid[i]),
            .full       (full[i])
        );
        assign head_meta[i] = head[i][META];
    end

    assign in_ready  = ~full & {N_CHANNELS{~reset}};
    assign push      = in_valid & in_ready;
    assign all_hdr   = &(head_valid & head_meta);
    assign out_data  = head;
    assign out_valid = (state_q == FWD) ? (head_valid & ~done_q) : '0;

`ifdef EVT_SYNC_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_q;
    logic          partial;

    // Some, but not all, channels are holding a header while waiting.
    assign partial      = (state_q == WAIT_HDR) && |(head_valid & head_meta) && !all_hdr;
    assign timeout_fire = partial && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_q       <= '0;
            err_timeout <= 1'b0;
        end else begin
            tmo_q <= (!partial || timeout_fire) ? '0 : tmo_q + TW'(1);
            if (timeout_fire) begin
                err_timeout <= 1'b1;
            end
        end
    end
`else
    assign timeout_fire = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        done_d       = done_q;
        hdr_d        = hdr_q;
        pop          = '0;
        err_evtid_d  = err_evtid;
        err_orphan_d = err_orphan;
        count_d      = event_count;
        if (state_q == WAIT_HDR) begin
            pop = head_valid & (~head_meta | {N_CHANNELS{timeout_fire}});
            if (|(head_valid & ~head_meta)) begin
                err_orphan_d = 1'b1;
            end
            if (all_hdr) begin
                state_d = FWD;
                done_d  = '0;
                hdr_d   = '0;
                for (int unsigned i = 1; i < N_CHANNELS; i++) begin
                    if (evtid_differs(EVTID_MAX_WIDTH'(head[i][EVTID_WIDTH-1:0]),
                                      EVTID_MAX_WIDTH'(head[0][EVTID_WIDTH-1:0]),
                                      EVTID_WIDTH)) begin
                        err_evtid_d = 1'b1;
                    end
                end
            end
        end else begin
            pop = out_valid & out_ready;
            // First metadata word popped is the header, the second is the footer.
            for (int unsigned i = 0; i < N_CHANNELS; i++) begin
                if (pop[i] && head_meta[i]) begin
                    if (hdr_q[i]) begin
                        done_d[i] = 1'b1;
                    end else begin
                        hdr_d[i] = 1'b1;
                    end
                end
            end
            if (&done_d) begin
                state_d = WAIT_HDR;
                count_d = event_count + 32'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= WAIT_HDR;
            done_q      <= '0;
            hdr_q       <= '0;
            err_evtid   <= 1'b0;
            err_orphan  <= 1'b0;
            event_count <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            hdr_q       <= hdr_d;
            err_evtid   <= err_evtid_d;
            err_orphan  <= err_orphan_d;
            event_count <= count_d;
        end
    end

endmodule

// File: tb/tb_evt_sync_aligner.sv
// Directed bench for evt_sync_aligner with a queue-level event model; EVT_SYNC_TIMEOUT_EN
// adds the timeout scenario.
module tb_evt_sync_aligner;

    localparam int DW    = 64;
    localparam int NC    = 2;
    localparam int DEPTH = 64;
    localparam int TO    = 16;
    localparam logic [DW:0] FOOT = {1'b1, 64'h0000_0000_0000_F00F};

    logic                   clock = 1'b0;
    logic                   reset;
    logic [NC-1:0][DW:0]    in_data, out_data;
    logic [NC-1:0]          in_valid, in_ready, out_valid, out_ready;
    logic                   err_evtid, err_orphan;
    logic [31:0]            event_count;
`ifdef EVT_SYNC_TIMEOUT_EN
    logic                   err_timeout;
`endif

    evt_sync_aligner #(
        .DATA_WIDTH     (DW),
        .FIFO_DEPTH     (6),
        .N_CHANNELS     (NC),
        .EVTID_WIDTH    (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err_evtid   (err_evtid),
        .err_orphan  (err_orphan),
`ifdef EVT_SYNC_TIMEOUT_EN
        .err_timeout (err_timeout),
`endif
        .event_count (event_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out [NC];

    // Model: one queue per channel plus event-level status.
    logic [DW:0]  q [NC][$];
    bit           m_fwd, m_err_id, m_err_orph, m_err_to;
    bit           m_done [NC];
    bit           m_hdr [NC];
    int unsigned  m_cnt, m_tmo;

    function automatic void chk(string name, logic [DW:0] act, logic [DW:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [DW:0] hw(int unsigned id);
        return {1'b1, 64'(id)};
    endfunction

    function automatic logic [DW:0] dwd(int unsigned v);
        return {1'b0, 64'(v)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            q[i].delete();
            m_done[i] = 1'b0;
            m_hdr[i]  = 1'b0;
        end
        m_fwd = 0; m_err_id = 0; m_err_orph = 0; m_err_to = 0; m_cnt = 0; m_tmo = 0;
    endtask

    task automatic model_edge();
        bit          can_push [NC];
        bit          all, any_hdr, tmo_fire;
        logic [DW:0] w;
        for (int i = 0; i < NC; i++) can_push[i] = (q[i].size() < DEPTH);
        if (!m_fwd) begin
            all = 1; any_hdr = 0; tmo_fire = 0;
            for (int i = 0; i < NC; i++) begin
                if (q[i].size() == 0) all = 0;
                else begin
                    w = q[i][0];
                    if (w[DW]) any_hdr = 1; else all = 0;
                end
            end
`ifdef EVT_SYNC_TIMEOUT_EN
            if (!all && any_hdr) begin
                m_tmo++;
                if (m_tmo == TO) begin
                    tmo_fire = 1; m_err_to = 1; m_tmo = 0;
                end
            end else m_tmo = 0;
`endif
            if (all) begin
                for (int i = 1; i < NC; i++) if (q[i][0][7:0] != q[0][0][7:0]) m_err_id = 1;
                m_fwd = 1;
                for (int i = 0; i < NC; i++) begin m_done[i] = 0; m_hdr[i] = 0; end
            end else begin
                for (int i = 0; i < NC; i++) begin
                    if (q[i].size() > 0) begin
                        w = q[i][0];
                        if (!w[DW]) m_err_orph = 1;
                        if (!w[DW] || tmo_fire) void'(q[i].pop_front());
                    end
                end
            end
        end else begin
            m_tmo = 0;
            for (int i = 0; i < NC; i++) begin
                if (q[i].size() > 0 && !m_done[i] && out_ready[i]) begin
                    w = q[i].pop_front();
                    if (w[DW]) begin
                        if (m_hdr[i]) m_done[i] = 1; else m_hdr[i] = 1;
                    end
                end
            end
            all = 1;
            for (int i = 0; i < NC; i++) if (!m_done[i]) all = 0;
            if (all) begin m_fwd = 0; m_cnt++; end
        end
        for (int i = 0; i < NC; i++) if (in_valid[i] && can_push[i]) q[i].push_back(in_data[i]);
    endtask

    task automatic tick();
        @(posedge clock);
        if (!reset) model_edge();
        #1;
    endtask

    task automatic drive(bit v0, logic [DW:0] d0, bit v1, logic [DW:0] d1);
        in_valid   = {v1, v0};
        in_data[0] = d0;
        in_data[1] = d1;
        tick();
    endtask

    task automatic idle(int n);
        in_valid = '0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        in_valid  = '0;
        out_ready = '0;
        reset     = 1'b1;
        model_reset();
        #1;
        chk("rst_out_valid", out_valid, '0);
        chk("rst_event_count", event_count, 0);
        chk("rst_in_ready", in_ready, '0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 2'b11);
        for (int i = 0; i < NC; i++) n_out[i] = 0;
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clock) begin
        bit ev;
        for (int i = 0; i < NC; i++) begin
            ev = !reset && m_fwd && (q[i].size() > 0) && !m_done[i];
            chk($sformatf("out_valid%0d", i), out_valid[i], ev);
            if (ev) chk($sformatf("out_data%0d", i), out_data[i], q[i][0]);
            chk($sformatf("in_ready%0d", i), in_ready[i], !reset && (q[i].size() < DEPTH));
            if (!reset && out_valid[i] && out_ready[i]) n_out[i]++;
        end
        chk("err_evtid", err_evtid, m_err_id);
        chk("err_orphan", err_orphan, m_err_orph);
        chk("event_count", event_count, m_cnt);
`ifdef EVT_SYNC_TIMEOUT_EN
        chk("err_timeout", err_timeout, m_err_to);
`endif
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        in_data = '0; in_valid = '0; out_ready = '0;
        reset = 1'b1;
        model_reset();
        #2;
        do_reset();

        // Basic event: header 0x05, three data words, footer.
        out_ready = 2'b11;
        drive(1, hw(5), 1, hw(5));
        chk("s1_ov_cycle1", out_valid, 2'b00);
        drive(1, dwd(1), 1, dwd(1));
        chk("s1_ov_cycle2", out_valid, 2'b11);
        chk("s1_hdr_out", out_data[0], hw(5));
        drive(1, dwd(2), 1, dwd(2));
        drive(1, dwd(3), 1, dwd(3));
        drive(1, FOOT, 1, FOOT);
        idle(8);
        chk("s1_words0", n_out[0], 5);
        chk("s1_words1", n_out[1], 5);
        chk("s1_events", event_count, 1);
        chk("s1_errs", {err_evtid, err_orphan}, 2'b00);

        // Skewed headers: channel 1 arrives 20 cycles late.
        do_reset();
        out_ready = 2'b11;
        drive(1, hw(7), 0, '0);
        idle(19);
`ifndef EVT_SYNC_TIMEOUT_EN
        chk("s2_ov_cycle20", out_valid, 2'b00);
`endif
        drive(0, '0, 1, hw(7));
`ifndef EVT_SYNC_TIMEOUT_EN
        chk("s2_ov_cycle21", out_valid, 2'b00);
`endif
        drive(1, dwd(10), 1, dwd(11));
`ifndef EVT_SYNC_TIMEOUT_EN
        chk("s2_ov_cycle22", out_valid, 2'b11);
`endif
        drive(1, FOOT, 1, FOOT);
        idle(6);
`ifndef EVT_SYNC_TIMEOUT_EN
        chk("s2_events", event_count, 1);
        chk("s2_words1", n_out[1], 3);
`endif

        // Event-ID mismatch still forwards.
        do_reset();
        out_ready = 2'b11;
        drive(1, hw(5), 1, hw(6));
        chk("s3_evtid_before", err_evtid, 1'b0);
        drive(1, dwd(9), 1, dwd(9));
        chk("s3_evtid_after", err_evtid, 1'b1);
        drive(1, FOOT, 1, FOOT);
        idle(6);
        chk("s3_events", event_count, 1);
        chk("s3_words0", n_out[0], 3);

        // Backpressure on channel 1 only.
        do_reset();
        out_ready = 2'b01;
        drive(1, hw(8), 1, hw(8));
        drive(1, dwd(1), 1, dwd(1));
        drive(1, dwd(2), 1, dwd(2));
        drive(1, FOOT, 1, FOOT);
        idle(6);
        chk("s4_words0", n_out[0], 4);
        chk("s4_words1", n_out[1], 0);
        chk("s4_ov_stalled", out_valid, 2'b10);
        chk("s4_events_mid", event_count, 0);
        out_ready = 2'b11;
        idle(6);
        chk("s4_words1_end", n_out[1], 4);
        chk("s4_events", event_count, 1);

        // Orphan word ahead of a header.
        do_reset();
        out_ready = 2'b11;
        drive(1, dwd(1), 0, '0);
        drive(1, hw(3), 1, hw(3));
        chk("s5_orphan", err_orphan, 1'b1);
        chk("s5_ov_wait", out_valid, 2'b00);
        drive(1, FOOT, 1, FOOT);
        chk("s5_ov_fwd", out_valid, 2'b11);
        chk("s5_hdr_out", out_data[1], hw(3));
        idle(5);
        chk("s5_events", event_count, 1);
        chk("s5_words0", n_out[0], 2);

        // Fill channel 0, then reset in the middle of an event.
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            drive(1, (k == 0) ? hw(1) : dwd(k), 0, '0);
`ifndef EVT_SYNC_TIMEOUT_EN
            if (k == DEPTH - 2) chk("s6_ready_63", in_ready[0], 1'b1);
            if (k == DEPTH - 1) chk("s6_ready_64", in_ready[0], 1'b0);
`endif
        end
        drive(1, dwd(99), 0, '0);
        drive(0, '0, 1, hw(1));
        idle(2);
`ifndef EVT_SYNC_TIMEOUT_EN
        chk("s6_ov_midevent", out_valid, 2'b11);
`endif
        do_reset();
        out_ready = 2'b11;
        drive(1, hw(4), 1, hw(4));
        drive(1, FOOT, 1, FOOT);
        idle(5);
        chk("s6_events_after", event_count, 1);

`ifdef EVT_SYNC_TIMEOUT_EN
        // Lone header times out.
        do_reset();
        drive(1, hw(2), 0, '0);
        idle(15);
        chk("s7_tmo_cycle16", err_timeout, 1'b0);
        tick();
        chk("s7_tmo_cycle17", err_timeout, 1'b1);
        chk("s7_ov", out_valid, 2'b00);
`endif

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
